// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter:
//   - parity mode encodings (2-bit parity_mode port)
//   - receiver FSM state enum
//   - parity helpers, so both ends compute the parity bit the same way
// ---------------------------------------------------------------------------
package uart_pkg;

  // parity_mode encodings. The value 1 is not listed and behaves like none.
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd2;
  localparam logic [1:0] PAR_ODD  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Parity bit that accompanies 'data' on the line: XOR of the data bits,
  // inverted for odd parity (mode bit 0 set).
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] mode);
    return (^data) ^ mode[0];
  endfunction

  // True when a parity bit is present in the frame for this mode.
  function automatic logic parity_enabled(input logic [1:0] mode);
    logic en;
    case (mode)
      PAR_EVEN, PAR_ODD: en = 1'b1;
      PAR_NONE:          en = 1'b0;
      default:           en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous serial input into the clk domain through two
// flops and flags the first cycle on which the synchronized line moves from
// the stop (idle) level to the start level.
//
// Ports:
//   clk          in   system clock
//   resetb       in   asynchronous active-low reset
//   i_rx         in   raw serial input, asynchronous to clk
//   o_rx_s       out  synchronized serial input
//   o_start_edge out  one-cycle pulse: o_rx_s went STOP_BIT -> START_BIT
// ---------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic START_BIT = 1'b0,
  parameter logic STOP_BIT  = 1'b1
) (
  input  logic clk,
  input  logic resetb,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_start_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour; blocking here would
  // collapse the two synchronizer stages into one.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      // Reset to the idle level so leaving reset never looks like a start.
      r_meta <= STOP_BIT;
      r_sync <= STOP_BIT;
      r_prev <= STOP_BIT;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx_s       = r_sync;
  assign o_start_edge = (r_prev == STOP_BIT) && (r_sync == START_BIT);

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8-bit asynchronous serial receiver. Frame: start bit, 8 data bits LSB
// first, optional parity bit, stop bit. Each bit lasts clk_div clk cycles
// and is sampled near its middle. One received byte is held in datao with a
// valid / re handshake; parity, framing and overrun errors are reported
// alongside it.
//
// Compile-time option:
//   UART_RX_MAJORITY_EN  defined   -> every bit is a 2-of-3 vote of the
//                                      samples at counts half-2, half-1,
//                                      half (needs clk_div >= 6)
//                        undefined -> single sample at count half-1
//
// Ports:
//   clk          in   system clock
//   resetb       in   asynchronous active-low reset
//   clk_div      in   bit period in clk cycles (>= 4), hold while busy
//   rx           in   serial input, asynchronous to clk
//   parity_mode  in   0 none, 2 even, 3 odd, 1 treated as none
//   re           in   read enable: acknowledges datao, clears valid/flags
//   datao        out  last received byte
//   valid        out  datao holds an unread byte
//   parity_err   out  parity mismatch on the byte in datao
//   frame_err    out  stop bit at the wrong level on the byte in datao
//   overrun      out  a frame completed while valid was already high
//   busy         out  a frame is in progress
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int   CLK_DIV_WIDTH = 8,
  parameter logic START_BIT     = 1'b0,
  parameter logic STOP_BIT      = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  input  logic                     rx,
  input  logic [1:0]               parity_mode,
  input  logic                     re,
  output logic [7:0]               datao,
  output logic                     valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     busy
);

  import uart_pkg::*;

  localparam logic [CLK_DIV_WIDTH-1:0] CNT_ONE = CLK_DIV_WIDTH'(1);
  localparam logic [CLK_DIV_WIDTH:0]   EXT_ONE = (CLK_DIV_WIDTH + 1)'(1);

  // -------------------------------------------------------------------------
  // Input synchronizer and start-edge detect
  // -------------------------------------------------------------------------
  logic w_rx_s;
  logic w_start_edge;

  uart_rx_sync #(
    .START_BIT (START_BIT),
    .STOP_BIT  (STOP_BIT)
  ) u_sync (
    .clk          (clk),
    .resetb       (resetb),
    .i_rx         (rx),
    .o_rx_s       (w_rx_s),
    .o_start_edge (w_start_edge)
  );

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  rx_state_e                r_state;
  rx_state_e                w_next;
  logic [CLK_DIV_WIDTH-1:0] r_cnt;
  logic [2:0]               r_bit_idx;
  logic [7:0]               r_shift;
  logic                     r_par_pend;

  logic [7:0]               r_datao;
  logic                     r_valid;
  logic                     r_parity_err;
  logic                     r_frame_err;
  logic                     r_overrun;

  // -------------------------------------------------------------------------
  // Bit timing
  // The counter restarts at 0 on entry to START and then free-runs modulo
  // clk_div for the whole frame, so the sample point of every bit sits at the
  // same count value and is exactly one bit period after the previous one.
  // The wrap test is done one bit wider so clk_div = 0 wraps every cycle
  // instead of counting through the full range; with the sample point
  // clamped to 0 for tiny clk_div, each bit state then exits promptly.
  // -------------------------------------------------------------------------
  logic [CLK_DIV_WIDTH-1:0] w_half;
  logic [CLK_DIV_WIDTH:0]   w_cnt_inc;
  logic                     w_wrap;
  logic                     w_tick;   // sample point of the current bit
  logic                     w_bit;    // decided level of the current bit

  assign w_half    = clk_div >> 1;
  assign w_cnt_inc = {1'b0, r_cnt} + EXT_ONE;
  assign w_wrap    = (w_cnt_inc >= {1'b0, clk_div});

`ifdef UART_RX_MAJORITY_EN
  // r_hist[0] / r_hist[1] hold rx_s from one / two cycles ago. At count half
  // they are the samples taken at half-1 and half-2.
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_hist <= {2{STOP_BIT}};
    end else begin
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_tick = (r_cnt == w_half);
  assign w_bit  = (w_rx_s & r_hist[0]) | (w_rx_s & r_hist[1]) |
                  (r_hist[0] & r_hist[1]);
`else
  logic [CLK_DIV_WIDTH-1:0] w_pt;

  assign w_pt   = (w_half == '0) ? '0 : (w_half - CNT_ONE);
  assign w_tick = (r_cnt == w_pt);
  assign w_bit  = w_rx_s;
`endif

  // -------------------------------------------------------------------------
  // Parity configuration, looked up live from parity_mode
  // -------------------------------------------------------------------------
  logic w_par_en;
  logic w_par_exp;

  assign w_par_en  = parity_enabled(parity_mode);
  assign w_par_exp = parity_bit(r_shift, parity_mode);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: w_next gets a default before the case so every path assigns it;
  // without that, any branch that skips the assignment infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start_edge) w_next = START;
      end
      START: begin
        // A start that is gone by mid-bit was a glitch: drop it silently.
        if (w_tick) w_next = (w_bit == START_BIT) ? DATA : IDLE;
      end
      DATA: begin
        if (w_tick && (r_bit_idx == 3'd7)) begin
          w_next = w_par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_tick) w_next = STOP;
      end
      STOP: begin
        // Return at mid-stop so the next start edge is never missed.
        if (w_tick) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  logic w_complete;
  assign w_complete = (r_state == STOP) && w_tick;

  // -------------------------------------------------------------------------
  // Bit counter, shift register, bit index, pending parity error
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_cnt      <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_par_pend <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt      <= '0;
        r_bit_idx  <= 3'd0;
        r_par_pend <= 1'b0;
      end else if (w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_inc[CLK_DIV_WIDTH-1:0];
      end

      if ((r_state == DATA) && w_tick) begin
        r_shift   <= {w_bit, r_shift[7:1]};   // LSB arrives first
        r_bit_idx <= r_bit_idx + 3'd1;
      end

      if ((r_state == PARITY) && w_tick) begin
        r_par_pend <= (w_bit != w_par_exp);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output holding register and handshake
  // A completing frame takes priority over re in the same cycle: the new
  // byte is presented and the read is considered to have hit the old byte,
  // so overrun is only raised when the old byte was never acknowledged.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_datao      <= 8'h00;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_complete) begin
      r_datao      <= r_shift;
      r_valid      <= 1'b1;
      r_parity_err <= r_par_pend;
      r_frame_err  <= (w_bit != STOP_BIT);
      r_overrun    <= r_valid && !re;
    end else if (re && r_valid) begin
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  assign datao      = r_datao;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. The stimulus thread pushes the expected
// received word into a queue and then serializes the frame onto rx; a
// separate monitor pops and compares whenever the receiver presents a byte
// (valid rising, or a new frame completing while valid is still high).
// ---------------------------------------------------------------------------
module tb_uart_rx;

  import uart_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic       clk;
  logic       resetb;
  logic [7:0] clk_div;
  logic       rx;
  logic [1:0] parity_mode;
  logic       re;
  logic [7:0] datao;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];

  uart_rx dut (
    .clk         (clk),
    .resetb      (resetb),
    .clk_div     (clk_div),
    .rx          (rx),
    .parity_mode (parity_mode),
    .re          (re),
    .datao       (datao),
    .valid       (valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  initial begin : monitor
    logic pv;
    logic pb;
    exp_t e;
    pv = 1'b0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (resetb && valid && (!pv || (pb && !busy))) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame: datao=0x%02h arrived, none expected",
                   datao);
        end else begin
          e = exp_q.pop_front();
          check("frame_datao",  32'(datao),      32'(e.data));
          check("frame_perr",   32'(parity_err), 32'(e.perr));
          check("frame_ferr",   32'(frame_err),  32'(e.ferr));
          check("frame_ovr",    32'(overrun),    32'(e.ovr));
        end
      end
      pv = valid;
      pb = busy;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (all driven on the falling edge)
  // -------------------------------------------------------------------------
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (int'(clk_div)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic has_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (has_par) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * int'(clk_div)) @(negedge clk);
  endtask

  // Wait (bounded) for valid, then acknowledge it and confirm it cleared.
  task automatic read_ack(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      if (valid) break;
      @(negedge clk);
    end
    check({name, "_valid"}, 32'(valid), 32'd1);
    re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    check({name, "_cleared"},
          32'({valid, parity_err, frame_err, overrun}), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  logic [7:0] lb_data [3];
  logic       lb_par  [3];
  logic       saw_busy;

  initial begin : stim
    n_checks    = 0;
    n_errors    = 0;
    resetb      = 1'b0;
    rx          = 1'b1;
    re          = 1'b0;
    clk_div     = 8'd16;
    parity_mode = PAR_NONE;

    repeat (4) @(negedge clk);
    check("reset_datao", 32'(datao), 32'h00);
    check("reset_flags",
          32'({valid, parity_err, frame_err, overrun, busy}), 32'd0);
    resetb = 1'b1;
    idle_bits(2);

    // 1) basic frame, no parity
    exp_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    read_ack("a5");
    idle_bits(1);

    // 2) even parity: 0x03 has two ones, so the correct parity bit is 0
    parity_mode = PAR_EVEN;
    exp_q.push_back('{data: 8'h03, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_frame(8'h03, 1'b1, 1'b0, 1'b1);
    read_ack("even_ok");
    exp_q.push_back('{data: 8'h03, perr: 1'b1, ferr: 1'b0, ovr: 1'b0});
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    read_ack("even_bad");
    idle_bits(1);

    // 3) odd parity at clk_div = 10; transmitter parity bits by hand:
    //    0x00 (0 ones) -> 1, 0xFF (8 ones) -> 1, 0x55 (4 ones) -> 1
    clk_div     = 8'd10;
    parity_mode = PAR_ODD;
    lb_data[0] = 8'h00; lb_par[0] = 1'b1;
    lb_data[1] = 8'hFF; lb_par[1] = 1'b1;
    lb_data[2] = 8'h55; lb_par[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{data: lb_data[k], perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
      send_frame(lb_data[k], 1'b1, lb_par[k], 1'b1);
      read_ack("odd_loop");
    end
    idle_bits(1);

    // 4) stop bit low, then the line stays low (break)
    clk_div     = 8'd16;
    parity_mode = PAR_NONE;
    exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b1, ovr: 1'b0});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    read_ack("break");
    repeat (40 * 16) @(negedge clk);
    check("break_no_valid", 32'({valid, busy}), 32'd0);
    idle_bits(2);

    // 5) 3-cycle glitch: busy pulses, no byte
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    check("glitch_busy_seen", 32'(saw_busy), 32'd1);
    check("glitch_idle", 32'({valid, busy}), 32'd0);
    idle_bits(1);

    //    back-to-back frames without a read in between
    exp_q.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    exp_q.push_back('{data: 8'h7E, perr: 1'b0, ferr: 1'b0, ovr: 1'b1});
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
    read_ack("overrun");
    idle_bits(1);

    // 6) reset in the middle of the data bits of 0xC3
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("mid_frame_busy", 32'(busy), 32'd1);
    resetb = 1'b0;
    rx     = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_reset_datao", 32'(datao), 32'h00);
    check("mid_reset_flags",
          32'({valid, parity_err, frame_err, overrun, busy}), 32'd0);
    resetb = 1'b1;
    idle_bits(12);
    check("post_reset_no_valid", 32'(valid), 32'd0);
    exp_q.push_back('{data: 8'h12, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    read_ack("after_reset");

    // Drain: every pushed expectation must have been consumed.
    for (int i = 0; i < 1000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
